// File: rtl/levit_frame_driver_pkg.sv
// Shared widths, config address map and FSM state encoding for the LeViT frame driver.
package levit_frame_driver_pkg;

  localparam int conv16_width = 16;
  localparam int conv8_width  = 8;
  localparam int conv4_width  = 4;
  localparam int att_width    = 16;

  localparam int CFG_F16_0 = 0;
  localparam int CFG_F8_0  = 3;
  localparam int CFG_F4_0  = 6;
  localparam int CFG_BIAS  = 9;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OUT} drv_state_t;

endpackage

// File: rtl/levit_frame_driver_watchdog.sv
// Run-time watchdog: cleared by load_i, counts while en_i, flags the final allowed cycle.
module drv_watchdog #(
  parameter int TIMEOUT = 1048576,
  parameter int TO_W    = 21
) (
  input  logic clk,
  input  logic rstn,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && (cnt_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/levit_frame_driver.sv
// Host-side driver: buffers a 16-row frame, holds filter/bias config, runs the
// accelerator until a rising end_sig (or watchdog expiry) and streams the result out.
module levit_frame_driver
  import levit_frame_driver_pkg::*;
#(
  parameter int ROWS    = 16,
  parameter int TIMEOUT = 1048576,
  parameter int TO_W    = 21
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         s_valid,
  input  logic [conv16_width-1:0]      s_data,
  output logic                         s_ready,
  input  logic                         cfg_we,
  input  logic [3:0]                   cfg_addr,
  input  logic [conv16_width-1:0]      cfg_data,
  output logic                         acc_en,
  output logic [ROWS*conv16_width-1:0] acc_r,
  output logic [3*conv16_width-1:0]    acc_f16,
  output logic [3*conv8_width-1:0]     acc_f8,
  output logic [3*conv4_width-1:0]     acc_f4,
  output logic [att_width-1:0]         acc_bias,
  input  logic                         acc_end,
  input  logic [att_width-1:0]         acc_result,
  output logic                         m_valid,
  output logic [att_width-1:0]         m_data,
  input  logic                         m_ready,
  output logic                         busy,
  output logic                         err
);

  localparam int RC_W = $clog2(ROWS);

  drv_state_t           state_q;
  logic [RC_W-1:0]      row_cnt_q;
  logic                 s_ready_q;
  logic                 acc_en_q;
  logic                 m_valid_q;
  logic                 err_q;
  logic                 acc_end_q;
  logic [att_width-1:0] m_data_q;
  logic [att_width-1:0] bias_q;

  logic row_hs, last_row, frame_done, cfg_wr, end_rise, wd_tc;

  // s_ready_q is only ever high in IDLE, so a handshake implies IDLE.
  assign row_hs     = s_valid && s_ready_q;
  assign last_row   = (row_cnt_q == RC_W'(ROWS - 1));
  assign frame_done = row_hs && last_row;
  assign cfg_wr     = cfg_we && (state_q == S_IDLE);
  assign end_rise   = acc_end && !acc_end_q;

  drv_watchdog #(
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) u_watchdog (
    .clk   (clk),
    .rstn  (rstn),
    .load_i(frame_done),
    .en_i  (state_q == S_RUN),
    .tc_o  (wd_tc)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      row_cnt_q <= '0;
      s_ready_q <= 1'b0;
      acc_en_q  <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      err_q     <= 1'b0;
      acc_end_q <= 1'b0;
    end else begin
      acc_end_q <= acc_end;
      unique case (state_q)
        S_IDLE: begin
          s_ready_q <= 1'b1;
          if (row_hs) begin
            err_q <= 1'b0;
            if (last_row) begin
              row_cnt_q <= '0;
              s_ready_q <= 1'b0;
              acc_en_q  <= 1'b1;
              state_q   <= S_RUN;
            end else begin
              row_cnt_q <= row_cnt_q + 1'b1;
            end
          end
        end
        S_RUN: begin
          // A captured edge wins over a watchdog expiry in the same cycle.
          if (end_rise) begin
            m_data_q  <= acc_result;
            m_valid_q <= 1'b1;
            acc_en_q  <= 1'b0;
            state_q   <= S_OUT;
          end else if (wd_tc) begin
            err_q     <= 1'b1;
            m_data_q  <= '0;
            acc_en_q  <= 1'b0;
            s_ready_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        S_OUT: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    logic [conv16_width-1:0] row_q;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        row_q <= '0;
      end else if (row_hs && (row_cnt_q == RC_W'(gi))) begin
        row_q <= s_data;
      end
    end
    assign acc_r[gi*conv16_width +: conv16_width] = row_q;
  end

  // Config is frozen outside IDLE so the accelerator sees stable filters.
  for (genvar gi = 0; gi < 3; gi++) begin : g_filt
    logic [conv16_width-1:0] f16_q;
    logic [conv8_width-1:0]  f8_q;
    logic [conv4_width-1:0]  f4_q;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        f16_q <= '0;
        f8_q  <= '0;
        f4_q  <= '0;
      end else if (cfg_wr) begin
        if (cfg_addr == 4'(CFG_F16_0 + gi)) f16_q <= cfg_data;
        if (cfg_addr == 4'(CFG_F8_0 + gi))  f8_q  <= cfg_data[conv8_width-1:0];
        if (cfg_addr == 4'(CFG_F4_0 + gi))  f4_q  <= cfg_data[conv4_width-1:0];
      end
    end
    assign acc_f16[gi*conv16_width +: conv16_width] = f16_q;
    assign acc_f8[gi*conv8_width +: conv8_width]    = f8_q;
    assign acc_f4[gi*conv4_width +: conv4_width]    = f4_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bias_q <= '0;
    end else if (cfg_wr && (cfg_addr == 4'(CFG_BIAS))) begin
      bias_q <= cfg_data[att_width-1:0];
    end
  end

  assign s_ready  = s_ready_q;
  assign acc_en   = acc_en_q;
  assign acc_bias = bias_q;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;

endmodule

// File: tb/tb_levit_frame_driver.sv
// Directed bench for levit_frame_driver: config table, frame/result flow,
// backpressure, level end_sig timeout, config lockout, async reset and row integrity.
module tb_levit_frame_driver;
  import levit_frame_driver_pkg::*;

  localparam int ROWS    = 16;
  localparam int TIMEOUT = 64;
  localparam int TO_W    = 7;

  logic                         clk = 1'b0;
  logic                         rstn;
  logic                         s_valid;
  logic [conv16_width-1:0]      s_data;
  logic                         s_ready;
  logic                         cfg_we;
  logic [3:0]                   cfg_addr;
  logic [conv16_width-1:0]      cfg_data;
  logic                         acc_en;
  logic [ROWS*conv16_width-1:0] acc_r;
  logic [3*conv16_width-1:0]    acc_f16;
  logic [3*conv8_width-1:0]     acc_f8;
  logic [3*conv4_width-1:0]     acc_f4;
  logic [att_width-1:0]         acc_bias;
  logic                         acc_end;
  logic [att_width-1:0]         acc_result;
  logic                         m_valid;
  logic [att_width-1:0]         m_data;
  logic                         m_ready;
  logic                         busy;
  logic                         err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    int          slot;
    logic [15:0] exp;
  } cfg_vec_t;

  cfg_vec_t                     vecs [16];
  logic [15:0]                  cfg_exp [10];
  logic [ROWS*conv16_width-1:0] exp_r;

  levit_frame_driver #(
    .ROWS   (ROWS),
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .acc_en    (acc_en),
    .acc_r     (acc_r),
    .acc_f16   (acc_f16),
    .acc_f8    (acc_f8),
    .acc_f4    (acc_f4),
    .acc_bias  (acc_bias),
    .acc_end   (acc_end),
    .acc_result(acc_result),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] cfg_act();
    logic [159:0] v;
    for (int i = 0; i < 3; i++) begin
      v[i*16 +: 16]     = 16'(acc_f16[i*conv16_width +: conv16_width]);
      v[(3+i)*16 +: 16] = 16'(acc_f8[i*conv8_width +: conv8_width]);
      v[(6+i)*16 +: 16] = 16'(acc_f4[i*conv4_width +: conv4_width]);
    end
    v[9*16 +: 16] = 16'(acc_bias);
    return v;
  endfunction

  function automatic logic [159:0] cfg_expv();
    logic [159:0] v;
    for (int i = 0; i < 10; i++) v[i*16 +: 16] = cfg_exp[i];
    return v;
  endfunction

  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
    $display("cfg write addr=%0d data=%h", a, d);
  endtask

  // Offers one row; optional simultaneous config write in the handshake cycle.
  task automatic send_row(input logic [15:0] w, input int gap, input logic do_cfg,
                          input logic [3:0] ca, input logic [15:0] cd);
    int n;
    s_valid = 1'b0;
    repeat (gap) tick();
    s_valid = 1'b1;
    s_data  = w;
    n = 0;
    while (!s_ready && n < 10) begin
      tick();
      n++;
    end
    chk("row_ready", 256'(s_ready), 256'(1));
    cfg_we = do_cfg; cfg_addr = ca; cfg_data = cd;
    tick();
    s_valid = 1'b0;
    cfg_we  = 1'b0;
    $display("row accepted data=%h", w);
  endtask

  initial begin
    logic ok;
    int   cnt;
    logic seen;

    rstn = 1'b0; s_valid = 1'b0; s_data = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    acc_end = 1'b0; acc_result = '0; m_ready = 1'b0;
    for (int i = 0; i < 10; i++) cfg_exp[i] = 16'h0;

    vecs[0] = '{4'd0,  16'hBEEF, 0,  16'hBEEF};
    vecs[1] = '{4'd4,  16'hABCD, 4,  16'h00CD};
    vecs[2] = '{4'd8,  16'h1237, 8,  16'h0007};
    vecs[3] = '{4'd9,  16'h00FF, 9,  16'h00FF};
    vecs[4] = '{4'd12, 16'h5555, -1, 16'h0000};
    vecs[5] = '{4'd15, 16'hFFFF, -1, 16'h0000};
    for (int i = 0; i < 10; i++) vecs[6+i] = '{4'(i), 16'(i + 1), i, 16'(i + 1)};

    // Reset state
    #12;
    chk("rst_acc_en", 256'(acc_en), 256'(0));
    chk("rst_m_valid", 256'(m_valid), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_s_ready", 256'(s_ready), 256'(0));
    chk("rst_err", 256'(err), 256'(0));
    chk("rst_acc_r", 256'(acc_r), 256'(0));
    chk("rst_cfg", 256'(cfg_act()), 256'(0));
    rstn = 1'b1;
    tick();
    chk("idle_s_ready", 256'(s_ready), 256'(1));

    // Config table
    for (int i = 0; i < 16; i++) begin
      cfg_write(vecs[i].addr, vecs[i].data);
      if (vecs[i].slot >= 0) cfg_exp[vecs[i].slot] = vecs[i].exp;
      chk($sformatf("cfg_vec%0d", i), 256'(cfg_act()), 256'(cfg_expv()));
    end

    // Frame and result
    for (int k = 0; k < ROWS; k++) begin
      send_row(16'(k), 0, 1'b0, 4'd0, 16'h0);
      exp_r[k*conv16_width +: conv16_width] = 16'(k);
    end
    chk("en_latency", 256'(acc_en), 256'(1));
    chk("run_busy", 256'(busy), 256'(1));
    cnt = 0; ok = 1'b1;
    for (int i = 0; i < 49; i++) begin
      if (acc_en) cnt++;
      if (acc_r !== exp_r || cfg_act() !== cfg_expv() || s_ready !== 1'b0) ok = 1'b0;
      tick();
    end
    if (acc_en) cnt++;
    acc_end = 1'b1; acc_result = 16'h1234;
    tick();
    chk("en_cycles", 256'(cnt), 256'(50));
    chk("run_stable", 256'(ok), 256'(1));
    chk("res_m_valid", 256'(m_valid), 256'(1));
    chk("res_m_data", 256'(m_data), 256'(16'h1234));
    chk("res_acc_en", 256'(acc_en), 256'(0));
    $display("result captured data=%h", m_data);

    // Output backpressure
    acc_result = 16'hDEAD; acc_end = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (m_valid !== 1'b1 || m_data !== 16'h1234 || s_ready !== 1'b0 || acc_en !== 1'b0) ok = 1'b0;
      tick();
    end
    chk("bp_hold", 256'(ok), 256'(1));
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("out_m_valid", 256'(m_valid), 256'(0));
    chk("out_s_ready", 256'(s_ready), 256'(1));
    chk("out_busy", 256'(busy), 256'(0));

    // Level end_sig: no capture, watchdog timeout, config lockout
    acc_end = 1'b1; acc_result = 16'h5A5A;
    for (int k = 0; k < ROWS; k++) send_row(16'h0100 + 16'(k), 0, 1'b0, 4'd0, 16'h0);
    cnt = 0; seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      cnt++;
      if (m_valid) seen = 1'b1;
      cfg_we = (i == 3); cfg_addr = 4'd9; cfg_data = 16'h00FF;
      tick();
    end
    cfg_we = 1'b0;
    chk("to_run_cycles", 256'(cnt), 256'(TIMEOUT));
    chk("to_no_valid", 256'(seen), 256'(0));
    chk("to_err", 256'(err), 256'(1));
    chk("to_m_data", 256'(m_data), 256'(0));
    chk("to_acc_en", 256'(acc_en), 256'(0));
    chk("lock_bias", 256'(acc_bias), 256'(16'h000A));
    $display("timeout seen run_cycles=%0d", cnt);
    cfg_write(4'd9, 16'h00FF);
    cfg_exp[9] = 16'h00FF;
    chk("idle_bias", 256'(acc_bias), 256'(16'h00FF));
    chk("err_sticky", 256'(err), 256'(1));
    acc_end = 1'b0;
    send_row(16'h0200, 0, 1'b0, 4'd0, 16'h0);
    chk("err_clear", 256'(err), 256'(0));

    // Reset mid-run
    for (int k = 1; k < ROWS; k++) send_row(16'h0200 + 16'(k), 0, 1'b0, 4'd0, 16'h0);
    repeat (9) tick();
    chk("pre_rst_en", 256'(acc_en), 256'(1));
    #2 rstn = 1'b0;
    #1;
    chk("arst_acc_en", 256'(acc_en), 256'(0));
    chk("arst_m_valid", 256'(m_valid), 256'(0));
    chk("arst_busy", 256'(busy), 256'(0));
    chk("arst_acc_r", 256'(acc_r), 256'(0));
    chk("arst_cfg", 256'(cfg_act()), 256'(0));
    $display("async reset applied mid-run");
    @(posedge clk);
    @(posedge clk);
    #3 rstn = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) cfg_exp[i] = 16'h0;

    // Row buffer integrity with random gaps; cfg write shares the row-15 handshake
    for (int k = 0; k < ROWS; k++) begin
      logic [15:0] w;
      w = 16'($urandom);
      exp_r[k*conv16_width +: conv16_width] = w;
      send_row(w, int'($urandom_range(0, 2)), k == ROWS - 1, 4'd1, 16'h7777);
    end
    cfg_exp[1] = 16'h7777;
    chk("int_acc_r", 256'(acc_r), 256'(exp_r));
    chk("int_cfg_same_cycle", 256'(cfg_act()), 256'(cfg_expv()));
    chk("int_acc_en", 256'(acc_en), 256'(1));
    s_valid = 1'b1; s_data = 16'hAAAA;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (s_ready !== 1'b0) ok = 1'b0;
      tick();
    end
    s_valid = 1'b0;
    chk("row17_refused", 256'(ok), 256'(1));
    chk("row17_acc_r", 256'(acc_r), 256'(exp_r));
    acc_result = 16'hC0DE; acc_end = 1'b1;
    tick();
    chk("int_m_valid", 256'(m_valid), 256'(1));
    chk("int_m_data", 256'(m_data), 256'(16'hC0DE));
    $display("result captured data=%h", m_data);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0; acc_end = 1'b0;
    chk("int_idle", 256'(busy), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
